// File: rtl/rv32_pkg.sv
// Shared RV32 writeback types: datapath widths and the queued register-write request record.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the two result producers, the arbiter and reg_file.
interface wb_arbiter_if;
    import rv32_pkg::*;

    logic                  a_valid;
    logic                  a_ready;
    logic [REG_ADDR_W-1:0] a_rd;
    logic [XLEN-1:0]       a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [REG_ADDR_W-1:0] b_rd;
    logic [XLEN-1:0]       b_data;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] Rd;
    logic [XLEN-1:0]       Write_data;
    logic [REG_ADDR_W-1:0] Rs1;
    logic [REG_ADDR_W-1:0] Rs2;
    logic                  fwd1_hit;
    logic [XLEN-1:0]       fwd1_data;
    logic                  fwd2_hit;
    logic [XLEN-1:0]       fwd2_data;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, Rs1, Rs2,
        output a_ready, b_ready, RegWrite, Rd, Write_data,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, Rs1, Rs2,
        input  a_ready, b_ready, RegWrite, Rd, Write_data,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
    );

endinterface

// File: rtl/wb_queue.sv
// Source-B writeback FIFO with kill-by-rd and two newest-first forwarding lookups.
module wb_queue
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  wb_req_t               i_push_req,
    input  logic                  i_pop,
    input  logic                  i_kill,
    input  logic [REG_ADDR_W-1:0] i_kill_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output wb_req_t               o_head,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_hit1,
    output logic [XLEN-1:0]       o_data1,
    output logic                  o_hit2,
    output logic [XLEN-1:0]       o_data2
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    wb_req_t          w_ent;
    logic             w_live;
    logic             w_m1;
    logic             w_m2;

    // Kill runs before the enqueue so a same-cycle push of the killed rd survives
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && r_mem[i].valid && (r_mem[i].rd == i_kill_rd)) begin
                    r_mem[i].valid <= 1'b0;
                end
            end
            if (i_push) begin
                r_mem[r_tail] <= i_push_req;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to newest so the last live match is the newest value
    always_comb begin
        o_hit1  = 1'b0;
        o_data1 = '0;
        o_hit2  = 1'b0;
        o_data2 = '0;
        w_ent   = '0;
        w_live  = 1'b0;
        w_m1    = 1'b0;
        w_m2    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent   = r_mem[r_head + PTR_W'(i)];
            w_live  = (CNT_W'(i) < r_count) && w_ent.valid;
            w_m1    = w_live && (w_ent.rd == i_rs1);
            w_m2    = w_live && (w_ent.rd == i_rs2);
            o_hit1  = o_hit1 | w_m1;
            o_data1 = w_m1 ? w_ent.data : o_data1;
            o_hit2  = o_hit2 | w_m2;
            o_data2 = w_m2 ? w_ent.data : o_data2;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_empty = (r_count == CNT_W'(0));
    assign o_full  = (r_count == CNT_FULL);

endmodule

// File: rtl/wb_arbiter.sv
// Serialises source-A and queued source-B register writebacks onto reg_file's single write port,
// with anti-starvation for B and forwarding of pending writes to the Rs1/Rs2 read path.
module wb_arbiter
    import rv32_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE_LIMIT);

    wb_req_t               w_q_head;
    wb_req_t               w_push_req;
    logic                  w_q_empty;
    logic                  w_q_full;
    logic                  w_q_hit1;
    logic                  w_q_hit2;
    logic [XLEN-1:0]       w_q_data1;
    logic [XLEN-1:0]       w_q_data2;
    logic                  w_a_ready;
    logic                  w_b_ready;
    logic                  w_a_win;
    logic                  w_push;
    logic                  w_pop;
    logic [XLEN:0]         w_fwd1;
    logic [XLEN:0]         w_fwd2;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_wdata;
    logic [ST_W-1:0]       r_starve;

    // Queue entry first (newest), then the output stage; x0 and reset never forward
    function automatic logic [XLEN:0] fwd_pick(
        input logic                  rst,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  q_hit,
        input logic [XLEN-1:0]       q_data,
        input logic                  o_we,
        input logic [REG_ADDR_W-1:0] o_rd,
        input logic [XLEN-1:0]       o_data
    );
        logic [XLEN:0] res;
        if (rst || (rs == 5'd0)) begin
            res = '0;
        end else if (q_hit) begin
            res = {1'b1, q_data};
        end else if (o_we && (o_rd == rs)) begin
            res = {1'b1, o_data};
        end else begin
            res = '0;
        end
        return res;
    endfunction

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_req (w_push_req),
        .i_pop      (w_pop),
        .i_kill     (w_a_win),
        .i_kill_rd  (bus.a_rd),
        .i_rs1      (bus.Rs1),
        .i_rs2      (bus.Rs2),
        .o_head     (w_q_head),
        .o_empty    (w_q_empty),
        .o_full     (w_q_full),
        .o_hit1     (w_q_hit1),
        .o_data1    (w_q_data1),
        .o_hit2     (w_q_hit2),
        .o_data2    (w_q_data2)
    );

    // Handshakes and arbitration; x0 requests handshake but never use the port or the queue
    always_comb begin
        w_a_ready        = !reset && !(!w_q_empty && (r_starve == ST_MAX));
        w_b_ready        = !reset && !w_q_full;
        w_a_win          = bus.a_valid && w_a_ready && (bus.a_rd != 5'd0);
        w_push           = bus.b_valid && w_b_ready && (bus.b_rd != 5'd0);
        w_pop            = !reset && !w_a_win && !w_q_empty;
        w_push_req.valid = 1'b1;
        w_push_req.rd    = bus.b_rd;
        w_push_req.data  = bus.b_data;
        w_fwd1 = fwd_pick(reset, bus.Rs1, w_q_hit1, w_q_data1, r_reg_write, r_rd, r_wdata);
        w_fwd2 = fwd_pick(reset, bus.Rs2, w_q_hit2, w_q_data2, r_reg_write, r_rd, r_wdata);
    end

    // Output stage: a killed head is popped with no write, Rd/Write_data hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_wdata     <= '0;
        end else if (w_a_win) begin
            r_reg_write <= 1'b1;
            r_rd        <= bus.a_rd;
            r_wdata     <= bus.a_data;
        end else if (w_pop && w_q_head.valid) begin
            r_reg_write <= 1'b1;
            r_rd        <= w_q_head.rd;
            r_wdata     <= w_q_head.data;
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    // Consecutive A wins while B waits; any pop or an empty queue restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_q_empty || w_pop) begin
            r_starve <= '0;
        end else if (w_a_win && (r_starve != ST_MAX)) begin
            r_starve <= r_starve + ST_W'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    assign bus.a_ready    = w_a_ready;
    assign bus.b_ready    = w_b_ready;
    assign bus.RegWrite   = r_reg_write;
    assign bus.Rd         = r_rd;
    assign bus.Write_data = r_wdata;
    assign bus.fwd1_hit   = w_fwd1[XLEN];
    assign bus.fwd1_data  = w_fwd1[XLEN-1:0];
    assign bus.fwd2_hit   = w_fwd2[XLEN];
    assign bus.fwd2_data  = w_fwd2[XLEN-1:0];

endmodule
